// File: rtl/tcad_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcad_seq_ctrl_pkg
// Description : Shared definitions for the TCAD host-side sequencer.
//               Provides the FSM state encoding and default sizing.
//               The default configuration-word width matches the
//               host-controller bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package tcad_seq_ctrl_pkg;

    localparam int unsigned c_HC_W_DEFAULT       = 256;
    localparam int unsigned c_CFG_DEPTH_DEFAULT  = 16;
    localparam int unsigned c_RC_W_DEFAULT       = 16;
    localparam int unsigned c_SETTLE_CYC_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tcad_seq_ctrl_cfg_buf.sv
`default_nettype none
// ============================================================================
// Module      : tcad_cfg_buf
// Description : Register-file buffer for configuration words.
//               Synchronous write port; registered read port. Storage is not
//               reset, only the read register is.
// Ports       : clk, rst (async active-low), wr_en/wr_addr/wr_data,
//               rd_en/rd_addr, rd_data (registered, holds when rd_en=0)
// Revision    : 1.0 - initial release
// ============================================================================
module tcad_cfg_buf #(
    parameter int unsigned HC_W  = 256,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [HC_W-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [HC_W-1:0] rd_data
);

    logic [HC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcad_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tcad_seq_ctrl
// Description : Host-side sequencer for the TCAD array. Buffers configuration
//               words, then per job drives init (LOAD), idles (SETTLE),
//               drives run (RUN) and pulses done.
// Ports       : clk, rst (async active-low)
//               cfg_wdata/cfg_wvalid/cfg_wready/cfg_clr - config write port
//               start/cfg_len/run_cycles/abort          - job control
//               init/run/host_controller                - to TCAD top
//               busy/done/err                           - status
// Options     : TCAD_SEQ_PERF_EN adds perf_run_cnt / perf_job_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tcad_seq_ctrl
    import tcad_seq_ctrl_pkg::*;
#(
    parameter int unsigned HC_W       = c_HC_W_DEFAULT,
    parameter int unsigned CFG_DEPTH  = c_CFG_DEPTH_DEFAULT,
    parameter int unsigned RC_W       = c_RC_W_DEFAULT,
    parameter int unsigned SETTLE_CYC = c_SETTLE_CYC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HC_W-1:0]            cfg_wdata,
    input  logic                       cfg_wvalid,
    output logic                       cfg_wready,
    input  logic                       cfg_clr,
    input  logic                       start,
    input  logic [$clog2(CFG_DEPTH):0] cfg_len,
    input  logic [RC_W-1:0]            run_cycles,
    input  logic                       abort,
    output logic                       init,
    output logic                       run,
    output logic [HC_W-1:0]            host_controller,
    output logic                       busy,
    output logic                       done,
    output logic                       err
`ifdef TCAD_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_run_cnt,
    output logic [15:0]                perf_job_cnt
`endif
);

    localparam int unsigned c_CW = $clog2(CFG_DEPTH) + 1;
    localparam int unsigned c_AW = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
    localparam logic [c_CW-1:0] c_PTR_FULL = c_CW'(CFG_DEPTH);
    localparam logic [RC_W-1:0] c_CNT_ONE  = RC_W'(1);
    localparam logic [RC_W-1:0] c_SETTLE   = RC_W'(SETTLE_CYC);

    seq_state_t        r_state;
    logic [RC_W-1:0]   r_cnt;
    logic [RC_W-1:0]   r_run_len;
    logic [c_AW-1:0]   r_ld_idx;
    logic [c_CW-1:0]   r_wr_ptr;

    logic              w_wr_en;
    logic              w_start_acc;
    logic              w_rd_en;
    logic [c_AW-1:0]   w_rd_addr;

    assign cfg_wready  = (r_state == ST_IDLE) && (r_wr_ptr < c_PTR_FULL) && !cfg_clr;
    assign w_wr_en     = cfg_wvalid && cfg_wready;
    // The pointer compared here is the pre-write value, so a word written in
    // the same cycle as start never counts toward this job's length.
    assign w_start_acc = (r_state == ST_IDLE) && start &&
                         (cfg_len != '0) && (cfg_len <= r_wr_ptr);

    // Word 0 is fetched on the accepting edge; each non-final LOAD cycle
    // fetches the next word so host_controller tracks the load index.
    assign w_rd_en   = w_start_acc ||
                       ((r_state == ST_LOAD) && (r_cnt != c_CNT_ONE) && !abort);
    assign w_rd_addr = (r_state == ST_IDLE) ? '0 : r_ld_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
        end else if (cfg_clr) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    tcad_cfg_buf #(
        .HC_W  (HC_W),
        .DEPTH (CFG_DEPTH),
        .AW    (c_AW)
    ) u_cfg_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[c_AW-1:0]),
        .wr_data (cfg_wdata),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (host_controller)
    );

    // Outputs are registered from the state being entered, so they line up
    // with r_state in every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_run_len <= '0;
            r_ld_idx  <= '0;
            init      <= 1'b0;
            run       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            init <= 1'b0;
            run  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        r_state   <= ST_LOAD;
                        r_cnt     <= RC_W'(cfg_len);
                        r_run_len <= run_cycles;
                        r_ld_idx  <= c_AW'(1);
                        init      <= 1'b1;
                        busy      <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != c_CNT_ONE) begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_ld_idx <= r_ld_idx + 1'b1;
                        init     <= 1'b1;
                        busy     <= 1'b1;
                    end else if (SETTLE_CYC != 0) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= c_SETTLE;
                        busy    <= 1'b1;
                    end else if (r_run_len == '0) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_cnt   <= r_run_len;
                        run     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != c_CNT_ONE) begin
                        r_cnt <= r_cnt - 1'b1;
                        busy  <= 1'b1;
                    end else if (r_run_len == '0) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_cnt   <= r_run_len;
                        run     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != c_CNT_ONE) begin
                        r_cnt <= r_cnt - 1'b1;
                        run   <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TCAD_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_run_cnt <= '0;
            perf_job_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                perf_run_cnt <= '0;
            end else if (((r_state == ST_RUN) || (r_state == ST_SETTLE)) &&
                         (perf_run_cnt != '1)) begin
                perf_run_cnt <= perf_run_cnt + 1'b1;
            end
            if (r_state == ST_DONE) begin
                perf_job_cnt <= perf_job_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/tcad_seq_ctrl.md
Name: tcad_seq_ctrl

Overview:
- Host-side sequencer for the TCAD array: buffers PE/SPM configuration words, then drives the array's `init`, `run` and `host_controller` inputs.
- Job sequence: configure (init), settle, execute (run), signal completion.
- Sits between host/bus interface and the TCAD top; replaces ad-hoc testbench driving of `init`/`run`.

Parameters:
- HC_W, 256, width of one configuration word (matches host_controller bus width)
- CFG_DEPTH, 16, number of configuration words the buffer holds
- RC_W, 16, width of run-cycle count
- SETTLE_CYC, 2, idle cycles between last init cycle and first run cycle (0 allowed)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-low
- cfg_wdata  in  HC_W  configuration word to store
- cfg_wvalid  in  1  write request
- cfg_wready  out  1  write accepted when cfg_wvalid & cfg_wready
- cfg_clr  in  1  empty config buffer (write pointer to 0)
- start  in  1  launch job (sampled in IDLE only)
- cfg_len  in  $clog2(CFG_DEPTH)+1  words to load for this job
- run_cycles  in  RC_W  cycles to hold run high
- abort  in  1  terminate current job
- init  out  1  to TCAD init
- run  out  1  to TCAD run
- host_controller  out  HC_W  to TCAD host_controller
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst=0, async): state IDLE, wr_ptr=0, all outputs 0, buffer contents don't-care.
- FSM states and exits:
  - IDLE: start → LOAD (or err pulse, stay IDLE).
  - LOAD: after cfg_len cycles → SETTLE, or → RUN if SETTLE_CYC=0.
  - SETTLE: after SETTLE_CYC cycles → RUN.
  - RUN: after run_cycles cycles → DONE.
  - DONE: 1 cycle → IDLE.
- Write path:
  - cfg_wready = IDLE & (wr_ptr<CFG_DEPTH) & ~cfg_clr (combinational).
  - Accepted word goes to buf[wr_ptr]; wr_ptr++.
  - cfg_clr wins over a same-cycle write (write dropped).
  - Buffer contents persist across jobs, so the same config can be re-run.
- Start:
  - Sampled only in IDLE; cfg_len and run_cycles are latched at acceptance.
  - Reject (err=1 next cycle, stay IDLE) if cfg_len==0 or cfg_len > wr_ptr. wr_ptr is the value before any same-cycle write.
  - start while busy is ignored, no err.
- Timing, with start accepted at edge T:
  - LOAD occupies cycles T+1..T+cfg_len: init=1; host_controller=buf[k] in cycle T+1+k (registered output).
  - SETTLE: init=0, run=0, host_controller holds last loaded word.
  - RUN: run=1 for exactly run_cycles cycles; host_controller holds. run_cycles=0 skips RUN and goes to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy is high from T+1 through the DONE cycle.
- Outputs in IDLE: host_controller holds its last value; init=run=0.
- Abort:
  - Any non-IDLE state: next cycle IDLE, init=run=0, no done pulse.
  - abort in IDLE has no effect.
  - abort and the final cycle of a phase coincide: abort wins.
- Counters:
  - Phase counter is RC_W bits, loaded at phase entry, decrements to 1.
  - cfg_len uses the full range 1..CFG_DEPTH.
- Async reset mid-job: immediately clears init/run. The buffer is not cleared, but wr_ptr=0, so the old contents are unusable.

Optional Feature:
- TCAD_SEQ_PERF_EN: adds outputs perf_run_cnt[31:0] and perf_job_cnt[15:0].
  - perf_run_cnt: cleared on start accept; +1 per cycle with run=1 and per SETTLE cycle; saturates at all-ones.
  - perf_job_cnt: +1 per done pulse; wraps.
  - Both reset to 0.
- Without the macro: ports absent, no counter logic.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=0, LOAD=1, SETTLE=2, RUN=3, DONE=4), default HC_W tied to the existing host-controller width define, CFG_DEPTH.
- One sub-module: tcad_cfg_buf, a simple register-file buffer (sync write port, registered read port indexed by load counter).
- FSM and counters stay in top.

Test Plan:
- Write 3 words (A0,A1,A2), start with cfg_len=3, run_cycles=5 → init=1 for 3 cycles showing A0,A1,A2; 2 idle cycles; run=1 for exactly 5 cycles; done pulse; busy low after.
- Start with cfg_len=4 while only 3 words stored; also cfg_len=0 → err pulse each time, busy stays 0, init never asserted.
- Fill 16 words → cfg_wready drops with wr_ptr=16, 17th write refused. Then assert cfg_clr and cfg_wvalid together → nothing written, wr_ptr=0.
- Assert abort on 3rd RUN cycle (run_cycles=10) → run=0 next cycle, no done, busy=0. Re-start immediately with cfg_len=3 → reloads same words.
- run_cycles=0, SETTLE_CYC=0 → LOAD directly followed by done pulse, run never high. Pulse start during RUN of another job → ignored.
- rst low mid-LOAD → init/run/busy/done go 0 asynchronously. After release, start with cfg_len=1 gives err (wr_ptr=0).
